// File: rtl/mips_pkg.sv
// Shared types and default widths for the pipeline memory interface.
package mips_pkg;

    localparam int unsigned DEF_AW  = 32;
    localparam int unsigned DEF_DW  = 32;
    localparam int unsigned DEF_BEW = DEF_DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DROP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the memory stage.
// Data accesses win over fetches. Only one transaction is in flight at a time.
// A fetch made stale by a redirect is completed at the memory side and then discarded.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_t state, nextState;
    logic       dLaunch, ifLaunch;
    logic       launchD, launchF, captureIf, captureD, txnEnd;

    // A requester whose done pulse is high advances this cycle. Its req still
    // describes the access that just finished, so it must not be relaunched.
    assign dLaunch  = d_req && !d_done;
    assign ifLaunch = if_req && !if_flush && !if_done;

    assign d_stall  = d_req && !d_done;
    assign if_stall = d_stall || (if_req && !if_done) || (state == DROP);

    // Next-state selection plus launch/capture strobes for the datapath.
    always_comb begin
        nextState = state;
        launchD   = 1'b0;
        launchF   = 1'b0;
        captureIf = 1'b0;
        captureD  = 1'b0;
        txnEnd    = 1'b0;
        case (state)
            IDLE: begin
                if (dLaunch)       launchD = 1'b1;
                else if (ifLaunch) launchF = 1'b1;
            end
            FETCH: begin
                if (mem_ack) begin
                    txnEnd    = 1'b1;
                    captureIf = !if_flush;
                    // The fetch stage cannot present a new address until its
                    // done cycle, so a follow-on fetch is arbitrated from IDLE.
                    if (dLaunch) launchD   = 1'b1;
                    else         nextState = IDLE;
                end else if (if_flush) begin
                    nextState = DROP;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    txnEnd   = 1'b1;
                    captureD = 1'b1;
                    if (ifLaunch) launchF   = 1'b1;
                    else          nextState = IDLE;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    txnEnd    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (launchD)      nextState = DATA;
        else if (launchF) nextState = FETCH;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Registered memory request, response capture and done pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            if_done <= captureIf;
            d_done  <= captureD;
            if (captureIf)            if_rdata <= mem_rdata;
            if (captureD && !mem_we)  d_rdata  <= mem_rdata;
            if (launchD) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end else if (launchF) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= '1;
            end else if (txnEnd) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// fetch/load/store mix checked against a word-level memory image.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mips_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                if_req, if_flush, if_done, if_stall;
    logic [AW-1:0]       if_addr;
    logic [DW-1:0]       if_rdata;
    logic                d_req, d_we, d_done, d_stall;
    logic [AW-1:0]       d_addr;
    logic [DW-1:0]       d_wdata, d_rdata;
    logic [DEF_BEW-1:0]  d_be;
    logic                mem_req, mem_we;
    logic                mem_ack = 1'b0;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata = '0;
    logic [DEF_BEW-1:0]  mem_be;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    int unsigned memLat = 0;
    bit          randLat = 1'b0;
    int unsigned waitCnt = 0;
    logic [DW-1:0] memArr [int unsigned];
    logic [DW-1:0] refImg [int unsigned];
    logic [DW-1:0] wTmp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
        return memArr.exists(a) ? memArr[a] : initWord(a);
    endfunction

    function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
        return refImg.exists(a) ? refImg[a] : initWord(a);
    endfunction

    // Memory responder: acks after memLat wait cycles; reads/writes in the ack cycle.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end else if (mem_req) begin
            if (waitCnt >= memLat) begin
                mem_ack   = 1'b1;
                mem_rdata = memRead(mem_addr);
                if (mem_we) begin
                    wTmp = memRead(mem_addr);
                    for (int unsigned b = 0; b < DEF_BEW; b++)
                        if (mem_be[b]) wTmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    memArr[mem_addr] = wTmp;
                end
                waitCnt = 0;
                if (randLat) memLat = $urandom_range(0, 3);
            end else begin
                mem_ack = 1'b0;
                waitCnt++;
            end
        end else begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end
    end

    task automatic clearInputs();
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearInputs();
        memLat = 0;
        randLat = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, if_done, d_done} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, mem_we, if_done, d_done});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be} !== '0) begin
            fails++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata, mem_be});
        end
        checks++;
        if ({if_rdata, d_rdata} !== '0) begin
            fails++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        end
        // requests while held in reset must not launch anything
        if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_addr = 32'h100;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL reset_hold_req: got %b expected 0", mem_req);
        end
        checks++;
        if ({d_stall, if_stall} !== 2'b11) begin
            fails++; $display("FAIL reset_stalls: got %b expected 11", {d_stall, if_stall});
        end
    endtask

    task automatic test_fetch_seq();
        logic [AW-1:0] pc;
        int unsigned nDone;
        bit expDone;
        doReset();
        pc = '0;
        nDone = 0;
        for (int unsigned cyc = 0; cyc < 30 && nDone < 3; cyc++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = pc;
            #1;
            expDone = (cyc == 2 + 3 * nDone);
            checks++;
            if (mem_req !== (cyc % 3 == 1)) begin
                fails++; $display("FAIL fetch_mem_req c%0d: got %b expected %b", cyc, mem_req, (cyc % 3 == 1));
            end
            if (cyc % 3 == 1) begin
                checks++;
                if (mem_addr !== pc) begin
                    fails++; $display("FAIL fetch_mem_addr: got %h expected %h", mem_addr, pc);
                end
            end
            checks++;
            if (if_done !== expDone) begin
                fails++; $display("FAIL fetch_done_timing c%0d: got %b expected %b", cyc, if_done, expDone);
            end
            checks++;
            if (if_stall !== !expDone) begin
                fails++; $display("FAIL fetch_stall c%0d: got %b expected %b", cyc, if_stall, !expDone);
            end
            if (expDone) begin
                checks++;
                if (if_rdata !== refRead(pc)) begin
                    fails++; $display("FAIL fetch_rdata %h: got %h expected %h", pc, if_rdata, refRead(pc));
                end
                nDone++;
                pc = pc + 32'h4;
            end
        end
        checks++;
        if (nDone != 3) begin
            fails++; $display("FAIL fetch_count: got %0d expected 3", nDone);
        end
        @(negedge clk); if_req = 1'b0;
    endtask

    task automatic test_priority();
        doReset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        refImg[32'h100] = 32'hDEADBEEF;
        #1;
        checks++;
        if ({mem_req, d_stall, if_stall} !== 3'b011) begin
            fails++; $display("FAIL prio_c0: got %b expected 011", {mem_req, d_stall, if_stall});
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF}) begin
            fails++; $display("FAIL prio_store_launch: got %h expected %h",
                {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
        end
        checks++;
        if ({if_stall, d_stall, d_done} !== 3'b110) begin
            fails++; $display("FAIL prio_c1_stalls: got %b expected 110", {if_stall, d_stall, d_done});
        end
        @(negedge clk); #1;
        checks++;
        if ({d_done, d_stall, if_stall} !== 3'b101) begin
            fails++; $display("FAIL prio_c2_done: got %b expected 101", {d_done, d_stall, if_stall});
        end
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            fails++; $display("FAIL prio_fetch_b2b: got %h expected %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h10});
        end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        checks++;
        if ({if_done, if_stall, d_done, mem_req} !== 4'b1000) begin
            fails++; $display("FAIL prio_c3_flags: got %b expected 1000", {if_done, if_stall, d_done, mem_req});
        end
        checks++;
        if (if_rdata !== refRead(32'h10)) begin
            fails++; $display("FAIL prio_if_rdata: got %h expected %h", if_rdata, refRead(32'h10));
        end
        checks++;
        if (memRead(32'h100) !== refRead(32'h100)) begin
            fails++; $display("FAIL prio_store_landed: got %h expected %h", memRead(32'h100), refRead(32'h100));
        end
        @(negedge clk); if_req = 1'b0;
    endtask

    task automatic test_flush_drop();
        int unsigned doneCyc;
        bit seen;
        doReset();
        memLat = 3;
        doneCyc = 0;
        seen = 1'b0;
        for (int unsigned cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin if_req = 1'b1; if_addr = 32'h40; end
            if (cyc == 2) begin if_flush = 1'b1; if_addr = 32'h80; end
            if (cyc == 4) if_flush = 1'b0;
            #1;
            if (cyc == 6) begin
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
                    fails++; $display("FAIL drop_refetch_addr: got %h expected %h", {mem_req, mem_addr}, {1'b1, 32'h80});
                end
            end
            if (cyc < 10) begin
                checks++;
                if ({if_done, if_stall} !== 2'b01) begin
                    fails++; $display("FAIL drop_no_done c%0d: got %b expected 01", cyc, {if_done, if_stall});
                end
            end
            if (if_done) begin
                seen = 1'b1;
                doneCyc = cyc;
                checks++;
                if (if_rdata !== refRead(32'h80)) begin
                    fails++; $display("FAIL drop_rdata: got %h expected %h", if_rdata, refRead(32'h80));
                end
            end
        end
        checks++;
        if (doneCyc != 10) begin
            fails++; $display("FAIL drop_done_cycle: got %0d expected 10", doneCyc);
        end
        @(negedge clk); if_req = 1'b0;
    endtask

    task automatic test_flush_ack();
        doReset();
        for (int unsigned cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h20;
        end
        #1;
        checks++;
        if ({if_done, if_rdata} !== {1'b1, refRead(32'h20)}) begin
            fails++; $display("FAIL flushack_first: got %h expected %h", {if_done, if_rdata}, {1'b1, refRead(32'h20)});
        end
        @(negedge clk); if_req = 1'b0;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h24; memLat = 1;
        @(negedge clk);
        @(negedge clk); if_flush = 1'b1;
        @(negedge clk); if_flush = 1'b0; if_req = 1'b0;
        #1;
        checks++;
        if ({if_done, mem_req} !== 2'b00) begin
            fails++; $display("FAIL flushack_done: got %b expected 00", {if_done, mem_req});
        end
        checks++;
        if (if_rdata !== refRead(32'h20)) begin
            fails++; $display("FAIL flushack_rdata_kept: got %h expected %h", if_rdata, refRead(32'h20));
        end
        @(negedge clk); #1;
        checks++;
        if (if_done !== 1'b0) begin
            fails++; $display("FAIL flushack_late_done: got %b expected 0", if_done);
        end
    endtask

    task automatic test_load_during_fetch();
        int unsigned dDoneCnt, dDoneCyc;
        doReset();
        memLat = 2;
        memArr[32'h200] = 32'h12345678;
        refImg[32'h200] = 32'h12345678;
        dDoneCnt = 0;
        dDoneCyc = 0;
        for (int unsigned cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin if_req = 1'b1; if_addr = 32'h30; end
            if (cyc == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF; end
            if (cyc == 5) if_req = 1'b0;
            if (cyc == 8) d_req = 1'b0;
            #1;
            if (cyc >= 1 && cyc <= 3) begin
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, 32'h30}) begin
                    fails++; $display("FAIL load_waits c%0d: got %h expected %h", cyc, {mem_req, mem_addr}, {1'b1, 32'h30});
                end
            end
            if (cyc == 4) begin
                checks++;
                if ({if_done, mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h200}) begin
                    fails++; $display("FAIL load_launch: got %h expected %h",
                        {if_done, mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 32'h200});
                end
            end
            if (cyc >= 1 && cyc <= 7) begin
                checks++;
                if (d_stall !== (cyc != 7)) begin
                    fails++; $display("FAIL load_stall c%0d: got %b expected %b", cyc, d_stall, (cyc != 7));
                end
            end
            if (d_done) begin
                dDoneCnt++;
                dDoneCyc = cyc;
                checks++;
                if (d_rdata !== refRead(32'h200)) begin
                    fails++; $display("FAIL load_rdata: got %h expected %h", d_rdata, refRead(32'h200));
                end
            end
        end
        checks++;
        if (dDoneCnt != 1 || dDoneCyc != 7) begin
            fails++; $display("FAIL load_done_pulse: got count %0d cycle %0d expected count 1 cycle 7", dDoneCnt, dDoneCyc);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        memLat = 5;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h140; d_wdata = $urandom(); d_be = 4'h3;
        @(negedge clk); #1;
        checks++;
        if ({mem_req, mem_we} !== 2'b11) begin
            fails++; $display("FAIL rstmid_launch: got %b expected 11", {mem_req, mem_we});
        end
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL rstmid_async_drop: got %b expected 0", mem_req);
        end
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_be, if_done, d_done, if_rdata, d_rdata} !== '0) begin
            fails++; $display("FAIL rstmid_outputs: got %h expected 0",
                {mem_we, mem_addr, mem_wdata, mem_be, if_done, d_done, if_rdata, d_rdata});
        end
        clearInputs();
        memLat = 0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({mem_req, if_done, d_done} !== 3'b000) begin
            fails++; $display("FAIL rstmid_idle: got %b expected 000", {mem_req, if_done, d_done});
        end
        for (int unsigned cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h8;
            #1;
            if (cyc == 1) begin
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, 32'h8}) begin
                    fails++; $display("FAIL rstmid_fetch_launch: got %h expected %h", {mem_req, mem_addr}, {1'b1, 32'h8});
                end
            end
            if (cyc == 2) begin
                checks++;
                if ({if_done, if_rdata} !== {1'b1, refRead(32'h8)}) begin
                    fails++; $display("FAIL rstmid_fetch_done: got %h expected %h", {if_done, if_rdata}, {1'b1, refRead(32'h8)});
                end
            end
        end
        @(negedge clk); if_req = 1'b0;
    endtask

    task automatic test_random();
        bit fAct, dAct, dWe, abort;
        logic [AW-1:0] pc, da;
        logic [DW-1:0] dW, lastLoad, cur;
        logic [DEF_BEW-1:0] dBe;
        int unsigned fAge, dAge, nF, nD;
        doReset();
        randLat = 1'b1;
        fAct = 1'b0; dAct = 1'b0; abort = 1'b0;
        pc = '0; da = '0; dW = '0; dBe = '0; dWe = 1'b0;
        lastLoad = '0;
        fAge = 0; dAge = 0; nF = 0; nD = 0;
        for (int unsigned cyc = 0; cyc < 2000 && !abort; cyc++) begin
            @(negedge clk);
            // fetch stage
            if (if_done) begin
                checks++;
                if (!fAct) begin
                    fails++; $display("FAIL rnd_spurious_if_done c%0d: got 1 expected 0", cyc);
                end else if (if_rdata !== refRead(pc)) begin
                    fails++; $display("FAIL rnd_if_rdata %h: got %h expected %h", pc, if_rdata, refRead(pc));
                end
                fAct = 1'b0;
                nF++;
                if_flush = 1'b0;
            end else begin
                if_flush = 1'b0;
                if (!fAct) begin
                    if ($urandom_range(0, 3) != 0) begin
                        fAct = 1'b1; fAge = 0;
                        pc = $urandom_range(0, 255) << 2;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    if_flush = 1'b1; fAge = 0;
                    pc = $urandom_range(0, 255) << 2;
                end
                if_req = fAct;
                if_addr = fAct ? pc : $urandom();
            end
            // memory stage
            if (d_done) begin
                checks++;
                if (!dAct) begin
                    fails++; $display("FAIL rnd_spurious_d_done c%0d: got 1 expected 0", cyc);
                end else if (!dWe) begin
                    if (d_rdata !== refRead(da)) begin
                        fails++; $display("FAIL rnd_load %h: got %h expected %h", da, d_rdata, refRead(da));
                    end
                    lastLoad = refRead(da);
                end else if (d_rdata !== lastLoad) begin
                    fails++; $display("FAIL rnd_store_kept_rdata: got %h expected %h", d_rdata, lastLoad);
                end
                dAct = 1'b0;
                nD++;
            end else begin
                if (!dAct && $urandom_range(0, 2) == 0) begin
                    dAct = 1'b1; dAge = 0;
                    dWe = 1'($urandom_range(0, 1));
                    da = 32'h400 + ($urandom_range(0, 255) << 2);
                    dW = $urandom();
                    dBe = 4'($urandom_range(1, 15));
                    if (dWe) begin
                        cur = refRead(da);
                        for (int unsigned b = 0; b < DEF_BEW; b++)
                            if (dBe[b]) cur[b*8 +: 8] = dW[b*8 +: 8];
                        refImg[da] = cur;
                    end
                end
                d_req = dAct; d_we = dWe; d_addr = da; d_wdata = dW; d_be = dBe;
            end
            if (fAct) fAge++;
            if (dAct) dAge++;
            if (fAge > 60 || dAge > 60) begin
                checks++;
                fails++;
                $display("FAIL rnd_timeout: got fetch age %0d data age %0d expected at most 60", fAge, dAge);
                abort = 1'b1;
            end
        end
        checks++;
        if (nF < 10 || nD < 10) begin
            fails++; $display("FAIL rnd_progress: got %0d fetches %0d data expected at least 10 each", nF, nD);
        end
        clearInputs();
        randLat = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_seq();
        test_priority();
        test_flush_drop();
        test_flush_ack();
        test_load_during_fetch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
